// File: rtl/router_rx_port.sv
// rtl/router_rx_port.sv - router output-channel drain: packet parser, parity check, elastic buffer
// Optional RXP_STATS_EN adds saturating pkt_cnt_o / err_cnt_o counters.
module router_rx_port #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_out_i,
  input  logic [7:0]  data_in_i,
  output logic        read_enb_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [7:0]  out_data_o,
  output logic        out_sop_o,
  output logic        out_eop_o,
  output logic        pkt_done_o,
  output logic        parity_err_o,
`ifdef RXP_STATS_EN
  output logic        pkt_abort_o,
  output logic [15:0] pkt_cnt_o,
  output logic [15:0] err_cnt_o
`else
  output logic        pkt_abort_o
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_HDR = 2'd0,
    S_PLD = 2'd1,
    S_PAR = 2'd2
  } state_e;

  state_e          state_q;
  logic [5:0]      rem_q;
  logic [7:0]      xor_q;
  logic [IW-1:0]   idle_q;
  logic            rd_vld_q;
  logic            pkt_done_q;
  logic            parity_err_q;
  logic            pkt_abort_q;

  logic [9:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;

  logic            push;
  logic            pop;
  logic [9:0]      push_data;
  logic [9:0]      head;
  logic [5:0]      hdr_len;
  logic            timeout_hit;

  assign hdr_len = data_in_i[7:2];

  // In-flight reads are counted so the buffer can never overflow.
  assign read_enb_o = rst_i && valid_out_i &&
                      (({1'b0, count_q} + {{CW{1'b0}}, rd_vld_q}) < (CW+1)'(DEPTH));

  // Registering the abort one count early lands the pulse on the TIMEOUT-th idle cycle.
  assign timeout_hit = (state_q != S_HDR) && !rd_vld_q && (idle_q == IW'(TIMEOUT - 2));

  always_comb begin
    push      = 1'b0;
    push_data = {data_in_i, 2'b00};
    if (rd_vld_q) begin
      case (state_q)
        S_HDR: begin
          push      = 1'b1;
          push_data = {data_in_i, 1'b1, (hdr_len == 6'd0)};
        end
        S_PLD: begin
          push      = 1'b1;
          push_data = {data_in_i, 1'b0, (rem_q == 6'd1)};
        end
        default: push = 1'b0;
      endcase
    end
  end

  assign pop = (count_q != '0) && out_ready_i;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= S_HDR;
      rem_q        <= '0;
      xor_q        <= '0;
      idle_q       <= '0;
      pkt_done_q   <= 1'b0;
      parity_err_q <= 1'b0;
      pkt_abort_q  <= 1'b0;
    end else begin
      pkt_done_q   <= 1'b0;
      parity_err_q <= 1'b0;
      pkt_abort_q  <= 1'b0;
      if (rd_vld_q) begin
        idle_q <= '0;
        case (state_q)
          S_HDR: begin
            xor_q   <= data_in_i;
            rem_q   <= hdr_len;
            state_q <= (hdr_len == 6'd0) ? S_PAR : S_PLD;
          end
          S_PLD: begin
            xor_q <= xor_q ^ data_in_i;
            rem_q <= rem_q - 1'b1;
            if (rem_q == 6'd1) begin
              state_q <= S_PAR;
            end
          end
          S_PAR: begin
            pkt_done_q   <= 1'b1;
            parity_err_q <= (xor_q != data_in_i);
            xor_q        <= '0;
            state_q      <= S_HDR;
          end
          default: state_q <= S_HDR;
        endcase
      end else if (state_q != S_HDR) begin
        if (timeout_hit) begin
          pkt_abort_q <= 1'b1;
          state_q     <= S_HDR;
          xor_q       <= '0;
          rem_q       <= '0;
          idle_q      <= '0;
        end else begin
          idle_q <= idle_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_vld_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_vld_q <= read_enb_o;
      count_q  <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  assign head         = mem_q[rd_ptr_q];
  assign out_valid_o  = (count_q != '0);
  assign out_data_o   = out_valid_o ? head[9:2] : 8'h00;
  assign out_sop_o    = out_valid_o && head[1];
  assign out_eop_o    = out_valid_o && head[0];
  assign pkt_done_o   = pkt_done_q;
  assign parity_err_o = parity_err_q;
  assign pkt_abort_o  = pkt_abort_q;

`ifdef RXP_STATS_EN
  logic [15:0] pkt_cnt_q;
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      if (pkt_done_q && (pkt_cnt_q != 16'hFFFF)) begin
        pkt_cnt_q <= pkt_cnt_q + 1'b1;
      end
      if (((pkt_done_q && parity_err_q) || pkt_abort_q) && (err_cnt_q != 16'hFFFF)) begin
        err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

  assign pkt_cnt_o = pkt_cnt_q;
  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: doc/router_rx_port.md
Name: router_rx_port

Overview:
- Downstream drain stage for one router output channel. One instance per channel.
- Consumes the router's valid_out_N / data_out_N pair and drives read_enb_N back, so the channel FIFO never stalls long enough to trigger the router's idle soft reset.
- Parses the packet: header byte (len = hdr[7:2], addr = hdr[1:0]), len payload bytes, then one parity byte.
- Forwards header and payload through an internal elastic buffer to a valid/ready sink. Drops the parity byte and reports parity status.

Parameters:
- DEPTH, 4, elastic buffer entries (2..16, power of 2).
- TIMEOUT, 64, idle cycles mid-packet before abort (>=2).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- valid_out  in  1  router channel not-empty.
- data_in  in  8  router data_out_N; valid 1 cycle after read_enb sampled high.
- read_enb  out  1  read strobe to router FIFO.
- out_valid  out  1  forwarded byte available.
- out_ready  in  1  sink accepts byte.
- out_data  out  8  forwarded byte.
- out_sop  out  1  byte is a header.
- out_eop  out  1  byte is last forwarded byte of its packet.
- pkt_done  out  1  1-cycle pulse: parity byte consumed.
- parity_err  out  1  qualifies pkt_done; 1 = mismatch.
- pkt_abort  out  1  1-cycle pulse: packet abandoned on timeout.

Behaviour:
- Reset (rst=0, async): all outputs 0. Buffer empty, FSM in HDR, counters and XOR cleared.
- Read issue: read_enb = valid_out && (buf_count + rd_vld_q) < DEPTH. Combinational; never high while valid_out=0.
- rd_vld_q is a register holding read_enb from the previous cycle. The parser consumes data_in only when rd_vld_q=1.
- Reads are continuous across packet boundaries; no per-packet request counter.
- FSM, advancing one step per consumed byte:
  - HDR: latch len, xor=byte, push {byte, sop=1, eop=(len==0)}. Go to PAR if len==0, else PLD with rem=len.
  - PLD: xor^=byte, push {byte, sop=0, eop=(rem==1)}, rem--. Go to PAR when rem reaches 0.
  - PAR: no push. Pulse pkt_done next cycle with parity_err=(xor!=byte). Go to HDR.
- Buffer: synchronous FIFO of {data, sop, eop}, DEPTH entries. Head drives out_* registered outputs.
  - out_valid = buffer non-empty.
  - Pop on out_valid && out_ready.
  - Simultaneous push and pop keep count constant.
  - Full buffer is impossible by construction of read_enb.
- Latency: byte on data_in reaches out_data 1 cycle after consumption, if the buffer was empty. Zero bubbles at out_ready=1 with valid_out held high.
- Backpressure: out_ready=0 holds out_data/out_sop/out_eop stable; read_enb falls once the buffer plus in-flight bytes reach DEPTH.
- Timeout:
  - idle counter increments each cycle the FSM is in PLD/PAR and no byte is consumed; clears on any consumed byte.
  - At idle==TIMEOUT-1: pulse pkt_abort, go to HDR, clear xor/rem.
  - Buffered bytes of the aborted packet still drain to the sink; the last one carries no eop.
  - No timeout in HDR.
- pkt_done/parity_err and pkt_abort are mutually exclusive in any cycle.
- Reset mid-packet discards all state immediately; the sink sees out_valid drop asynchronously.

Optional Feature:
- Macro RXP_STATS_EN.
- Defined: adds outputs pkt_cnt[15:0] and err_cnt[15:0].
  - pkt_cnt increments on pkt_done.
  - err_cnt increments on pkt_done&&parity_err or on pkt_abort.
  - Both saturate at 16'hFFFF; reset 0.
- Undefined: ports and counters absent; other behaviour identical.

Test Plan:
- Header 8'h0D (len 3, addr 1), payload 11,22,33, parity = XOR of all four, valid_out high, out_ready=1. Expect out_data D,11,22,33; sop on D, eop on 33; pkt_done=1, parity_err=0 one cycle after parity consumed.
- Same packet with parity byte flipped. Expect identical forwarded bytes; pkt_done=1 with parity_err=1.
- len=0 header 8'h02, parity 8'h02. Expect single byte with sop=eop=1, parity_err=0. A back-to-back second packet is parsed with no idle cycle.
- out_ready=0 for 20 cycles during a len-10 packet, DEPTH=4. Expect read_enb low after 4 outstanding bytes, out_data stable, no byte lost or duplicated after release.
- valid_out dropped after 2 of 5 payload bytes, held low 64 cycles. Expect pkt_abort pulse on the 64th idle cycle and no pkt_done. A following good packet is parsed correctly.
- rst asserted mid-payload. Expect all outputs 0 immediately; after release the first consumed byte is treated as a header.
